// File: rtl/can_pkg.sv
// Shared CAN definitions: decoder states, bit-level constants
// and bus levels used by the destuffer, frame FSM and encoder.
package can_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_FRAME,
    ST_ERROR
  } can_state_e;

  localparam int CAN_STUFF_LEN = 5;
  localparam int CAN_IDLE_BITS = 11;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_run_counter.sv
// Saturating run counter; clear and increment together restart
// the run at one.
module can_run_counter
  import can_pkg::*;
#(
  parameter int W   = 4,
  parameter int MAX = CAN_IDLE_BITS
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;
  logic [W-1:0] w_nxt;

  always_comb begin
    w_base = i_clr ? '0 : r_cnt;
    w_nxt  = w_base;
    if (i_inc && (w_base < W'(MAX)))
      w_nxt = w_base + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= w_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN receive front end: idle/SOF tracking, stuff-bit removal and
// stuff-error detection feeding the CRC-15 checker.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int IDLE_BITS = CAN_IDLE_BITS,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             RESET_N,
  input  logic             SAMPLE,
  input  logic             RXBIT,
  input  logic             STUFF_EN,
  output logic             BITOUT,
  output logic             BITSTB,
  output logic             CRC_CLEAR,
  output logic             SOF,
  output logic             BUS_IDLE,
  output logic             STUFF_ERR,
  output logic [CNT_W-1:0] BITCNT
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam int REC_W = $clog2(IDLE_BITS + 1);

  can_state_e r_state;
  can_state_e w_state_nxt;

  logic             r_last;
  logic             r_sof_pend;
  logic             r_bitout;
  logic             r_bitstb;
  logic             r_crc_clr;
  logic             r_sof;
  logic             r_stuff_err;
  logic [CNT_W-1:0] r_bitcnt;

  logic [RUN_W-1:0] w_run_cnt;
  logic [REC_W-1:0] w_rec_cnt;
  logic w_run_clr, w_run_inc;
  logic w_rec_clr, w_rec_inc;
  logic w_pass, w_sof, w_err;
  logic w_same, w_run_full, w_rec_hit;

  can_run_counter #(.W(RUN_W), .MAX(STUFF_LEN)) u_run (
    .i_clk   (clock),
    .i_rst_n (RESET_N),
    .i_en    (SAMPLE),
    .i_clr   (w_run_clr),
    .i_inc   (w_run_inc),
    .o_cnt   (w_run_cnt)
  );

  can_run_counter #(.W(REC_W), .MAX(IDLE_BITS)) u_rec (
    .i_clk   (clock),
    .i_rst_n (RESET_N),
    .i_en    (SAMPLE),
    .i_clr   (w_rec_clr),
    .i_inc   (w_rec_inc),
    .o_cnt   (w_rec_cnt)
  );

  assign w_same     = (RXBIT == r_last);
  assign w_run_full = (w_run_cnt == RUN_W'(STUFF_LEN));
  // This sample is the one that completes the idle run.
  assign w_rec_hit  = (RXBIT == CAN_RECESSIVE) &&
                      (w_rec_cnt >= REC_W'(IDLE_BITS - 1));

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= ST_WAIT_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pass      = 1'b0;
    w_sof       = 1'b0;
    w_err       = 1'b0;
    w_run_clr   = 1'b0;
    w_run_inc   = 1'b0;
    w_rec_clr   = (RXBIT == CAN_DOMINANT);
    w_rec_inc   = (RXBIT == CAN_RECESSIVE);
    if (SAMPLE) begin
      unique case (r_state)
        ST_WAIT_IDLE, ST_ERROR: begin
          if (w_rec_hit)
            w_state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (RXBIT == CAN_DOMINANT) begin
            w_sof       = 1'b1;
            w_run_clr   = 1'b1;
            w_run_inc   = 1'b1;
            w_state_nxt = ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (!STUFF_EN) begin
            w_pass    = 1'b1;
            w_run_clr = 1'b1;
            w_run_inc = 1'b1;
            if (w_rec_hit)
              w_state_nxt = ST_IDLE;
          end else if (!w_run_full) begin
            w_pass    = 1'b1;
            w_rec_clr = 1'b1;
            w_rec_inc = 1'b0;
            w_run_clr = !w_same;
            w_run_inc = 1'b1;
          end else if (!w_same) begin
            w_rec_clr = 1'b1;
            w_rec_inc = 1'b0;
            w_run_clr = 1'b1;
            w_run_inc = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_rec_clr   = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last      <= CAN_RECESSIVE;
      r_sof_pend  <= 1'b0;
      r_bitout    <= 1'b0;
      r_bitstb    <= 1'b0;
      r_crc_clr   <= 1'b0;
      r_sof       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_bitcnt    <= '0;
    end else begin
      r_sof_pend <= w_sof;
      r_crc_clr  <= w_sof;
      r_sof      <= w_sof;
      r_bitstb   <= w_pass | r_sof_pend;
      if (r_sof_pend)
        r_bitout <= CAN_DOMINANT;
      else if (w_pass)
        r_bitout <= RXBIT;
      if (w_sof)
        r_bitcnt <= '0;
      else if ((w_pass | r_sof_pend) && !(&r_bitcnt))
        r_bitcnt <= r_bitcnt + 1'b1;
      if (w_sof)
        r_stuff_err <= 1'b0;
      else if (w_err)
        r_stuff_err <= 1'b1;
      if (SAMPLE)
        r_last <= RXBIT;
    end
  end

  assign BITOUT    = r_bitout;
  assign BITSTB    = r_bitstb;
  assign CRC_CLEAR = r_crc_clr;
  assign SOF       = r_sof;
  assign BUS_IDLE  = (r_state == ST_IDLE);
  assign STUFF_ERR = r_stuff_err;
  assign BITCNT    = r_bitcnt;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboard bench for can_bit_destuffer: stimulus queues expected
// strobes, a negedge monitor pops and checks them.
module tb_can_bit_destuffer;

  localparam int EX_NONE = 0;
  localparam int EX_BIT  = 1;
  localparam int EX_SOF  = 2;
  localparam int K_SOF   = 0;
  localparam int K_BIT   = 1;

  typedef struct {
    int   kind;
    logic bv;
    int   cnt;
    int   cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SAMPLE = 1'b0;
  logic       RXBIT = 1'b1;
  logic       STUFF_EN = 1'b0;
  logic       BITOUT, BITSTB, CRC_CLEAR, SOF, BUS_IDLE, STUFF_ERR;
  logic [7:0] BITCNT;

  exp_t        q[$];
  int          cyc = 0;
  int          exp_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [14:0] crc_mon = '0;
  logic [14:0] crc_ref;
  logic [6:0]  ref_bits;

  can_bit_destuffer #(.STUFF_LEN(5), .IDLE_BITS(11), .CNT_W(8)) dut (
    .clock     (clock),
    .RESET_N   (RESET_N),
    .SAMPLE    (SAMPLE),
    .RXBIT     (RXBIT),
    .STUFF_EN  (STUFF_EN),
    .BITOUT    (BITOUT),
    .BITSTB    (BITSTB),
    .CRC_CLEAR (CRC_CLEAR),
    .SOF       (SOF),
    .BUS_IDLE  (BUS_IDLE),
    .STUFF_ERR (STUFF_ERR),
    .BITCNT    (BITCNT)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [14:0] crc_step(input logic [14:0] c,
                                           input logic b);
    logic nx;
    logic [14:0] r;
    nx = b ^ c[14];
    r  = {c[13:0], 1'b0};
    if (nx) r = r ^ 15'h4599;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (BITSTB || CRC_CLEAR || SOF) begin
      check("stb_exclusive", int'(BITSTB && CRC_CLEAR), 0);
      check("sof_eq_clear", int'(SOF), int'(CRC_CLEAR));
      if (q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        check("strobe_kind", CRC_CLEAR ? K_SOF : K_BIT, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("bitcnt", int'(BITCNT), e.cnt);
        if (e.kind == K_BIT)
          check("bitout", int'(BITOUT), int'(e.bv));
        else
          check("sof_err_clr", int'(STUFF_ERR), 0);
      end
      if (CRC_CLEAR) crc_mon <= '0;
      else if (BITSTB) crc_mon <= crc_step(crc_mon, BITOUT);
    end
  end

  task automatic smp(input logic b, input logic en, input int ex);
    exp_t e;
    int   ed;
    @(negedge clock);
    ed = cyc + 1;
    if (ex == EX_SOF) begin
      exp_cnt = 0;
      e.kind = K_SOF; e.bv = 1'b0; e.cnt = 0; e.cyc = ed;
      q.push_back(e);
      exp_cnt = 1;
      e.kind = K_BIT; e.bv = 1'b0; e.cnt = 1; e.cyc = ed + 1;
      q.push_back(e);
    end else if (ex == EX_BIT) begin
      if (exp_cnt < 255) exp_cnt++;
      e.kind = K_BIT; e.bv = b; e.cnt = exp_cnt; e.cyc = ed;
      q.push_back(e);
    end
    SAMPLE   = 1'b1;
    RXBIT    = b;
    STUFF_EN = en;
    @(negedge clock);
    SAMPLE   = 1'b0;
    RXBIT    = ~b;
    STUFF_EN = ~en;
    repeat (2) @(negedge clock);
  endtask

  task automatic burst(input logic b, input logic en, input int ex,
                       input int n);
    for (int i = 0; i < n; i++) smp(b, en, ex);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clock);
    check(name, q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_bitout"}, int'(BITOUT), 0);
    check({tag, "_bitstb"}, int'(BITSTB), 0);
    check({tag, "_crcclr"}, int'(CRC_CLEAR), 0);
    check({tag, "_sof"}, int'(SOF), 0);
    check({tag, "_idle"}, int'(BUS_IDLE), 0);
    check({tag, "_serr"}, int'(STUFF_ERR), 0);
    check({tag, "_bitcnt"}, int'(BITCNT), 0);
  endtask

  initial begin
    ref_bits = 7'b0000010;
    crc_ref  = '0;
    for (int i = 6; i >= 0; i--) crc_ref = crc_step(crc_ref, ref_bits[i]);

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    RESET_N = 1'b1;

    // idle detection with restart at count 7
    burst(1'b1, 1'b0, EX_NONE, 7);
    smp(1'b0, 1'b0, EX_NONE);
    burst(1'b1, 1'b0, EX_NONE, 10);
    check("idle_after10", int'(BUS_IDLE), 0);
    smp(1'b1, 1'b0, EX_NONE);
    check("idle_after11", int'(BUS_IDLE), 1);

    // SOF then destuff 0,0,0,0,[1],1,0
    smp(1'b0, 1'b1, EX_SOF);
    check("sof_idle_low", int'(BUS_IDLE), 0);
    burst(1'b0, 1'b1, EX_BIT, 4);
    smp(1'b1, 1'b1, EX_NONE);
    smp(1'b1, 1'b1, EX_BIT);
    smp(1'b0, 1'b1, EX_BIT);
    drain("drain_destuff");
    check("destuff_cnt", int'(BITCNT), 7);
    check("destuff_crc", int'(crc_mon), int'(crc_ref));
    check("destuff_noerr", int'(STUFF_ERR), 0);

    // STUFF_EN=0 window: recessive bits all pass, then back-to-back SOF
    burst(1'b1, 1'b0, EX_BIT, 10);
    check("win_idle10", int'(BUS_IDLE), 0);
    smp(1'b1, 1'b0, EX_BIT);
    check("win_idle11", int'(BUS_IDLE), 1);
    check("win_noerr", int'(STUFF_ERR), 0);
    check("win_cnt", int'(BITCNT), 18);
    smp(1'b0, 1'b1, EX_SOF);

    // stuff error on six dominant bits
    burst(1'b0, 1'b1, EX_BIT, 4);
    smp(1'b0, 1'b1, EX_NONE);
    drain("drain_err1");
    check("err1_set", int'(STUFF_ERR), 1);
    check("err1_cnt", int'(BITCNT), 5);
    burst(1'b1, 1'b0, EX_NONE, 10);
    check("err1_idle10", int'(BUS_IDLE), 0);
    smp(1'b1, 1'b0, EX_NONE);
    check("err1_idle11", int'(BUS_IDLE), 1);
    check("err1_sticky", int'(STUFF_ERR), 1);
    smp(1'b0, 1'b1, EX_SOF);
    check("err1_cleared", int'(STUFF_ERR), 0);

    // recessive stuff error: the error sample opens the idle run
    burst(1'b1, 1'b1, EX_BIT, 5);
    smp(1'b1, 1'b1, EX_NONE);
    check("err2_set", int'(STUFF_ERR), 1);
    burst(1'b1, 1'b0, EX_NONE, 9);
    check("err2_idle9", int'(BUS_IDLE), 0);
    smp(1'b1, 1'b0, EX_NONE);
    check("err2_idle10", int'(BUS_IDLE), 1);
    smp(1'b0, 1'b1, EX_SOF);
    check("err2_cleared", int'(STUFF_ERR), 0);

    // BITCNT saturation
    for (int i = 0; i < 260; i++) smp(logic'(i % 2 == 0), 1'b0, EX_BIT);
    drain("drain_sat");
    check("sat_cnt", int'(BITCNT), 255);
    burst(1'b1, 1'b0, EX_BIT, 11);
    check("sat_idle", int'(BUS_IDLE), 1);
    check("sat_hold", int'(BITCNT), 255);

    // reset mid-frame
    smp(1'b0, 1'b1, EX_SOF);
    for (int i = 0; i < 20; i++) smp(logic'(i % 2 == 0), 1'b0, EX_BIT);
    drain("drain_pre_rst");
    check("pre_rst_cnt", int'(BITCNT), 21);
    #3 RESET_N = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clock);
    RESET_N = 1'b1;
    burst(1'b1, 1'b0, EX_NONE, 10);
    smp(1'b0, 1'b1, EX_NONE);
    burst(1'b1, 1'b0, EX_NONE, 10);
    check("rst_idle10", int'(BUS_IDLE), 0);
    smp(1'b1, 1'b0, EX_NONE);
    check("rst_idle11", int'(BUS_IDLE), 1);
    smp(1'b0, 1'b1, EX_SOF);
    drain("drain_final");
    check("final_cnt", int'(BITCNT), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
- Decoder front stage between the bit-timing sampler and the CRC-15 checker / frame FSM.
- Consumes one sampled bus bit per SAMPLE strobe and tracks bus idle / start-of-frame.
- Removes CAN stuff bits inside the stuffing window and flags stuff errors.
- Emits a destuffed bit stream (BITOUT/BITSTB) plus a CRC clear pulse sized to drive the CRC checker's BITVAL/clock/CLEAR directly.

Parameters:
- STUFF_LEN, 5, equal-bit run length after which a complement stuff bit is mandatory.
- IDLE_BITS, 11, consecutive recessive samples that declare bus idle.
- CNT_W, 8, width of destuffed-bit counter BITCNT.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SAMPLE  input  1  one-cycle strobe: RXBIT valid at sample point.
- RXBIT  input  1  sampled bus level (1 = recessive).
- STUFF_EN  input  1  from frame FSM: high while SOF..CRC sequence is being received; sampled only on SAMPLE cycles.
- BITOUT  output  1  destuffed data bit, valid when BITSTB high; holds otherwise.
- BITSTB  output  1  one-cycle strobe per destuffed bit (CRC checker clock).
- CRC_CLEAR  output  1  one-cycle pulse at SOF, before the SOF BITSTB.
- SOF  output  1  one-cycle pulse, same cycle as CRC_CLEAR.
- BUS_IDLE  output  1  level: high in IDLE state.
- STUFF_ERR  output  1  sticky level: set on stuff violation, cleared at next SOF.
- BITCNT  output  CNT_W  destuffed bits since SOF, including SOF; saturates at all-ones.

Behaviour:
- Reset (async, RESET_N=0):
  - State WAIT_IDLE.
  - All outputs 0.
  - Recessive counter 0, run counter 0, last-bit register 1.
  - Takes effect mid-frame too; no further strobes until idle is re-detected.
- All state updates occur only on SAMPLE cycles. Outputs are registered, so every strobe appears exactly 1 cycle after its SAMPLE.
- States: WAIT_IDLE, IDLE, FRAME, ERROR.
- Recessive counter:
  - Counts consecutive RXBIT=1 samples in WAIT_IDLE, ERROR, and FRAME while STUFF_EN=0.
  - Any RXBIT=0 zeroes it.
  - Saturates at IDLE_BITS.
- WAIT_IDLE / ERROR: when the counter reaches IDLE_BITS on a SAMPLE, go to IDLE. BUS_IDLE goes high on the next cycle.
- IDLE, SAMPLE with RXBIT=0 (SOF):
  - Cycle t+1: CRC_CLEAR=1, SOF=1, STUFF_ERR cleared, BITCNT=0, BUS_IDLE=0.
  - Cycle t+2: BITSTB=1, BITOUT=0, BITCNT=1.
  - Run counter=1, last=0; go to FRAME.
  - This delayed SOF strobe is the only 2-cycle latency case.
- FRAME, SAMPLE with STUFF_EN=1:
  - Run counter < STUFF_LEN: pass the bit (BITSTB at t+1, BITCNT++). Run=run+1 if RXBIT==last, else 1; last=RXBIT.
  - Run counter == STUFF_LEN and RXBIT != last: stuff bit. No BITSTB, BITCNT unchanged; run=1, last=RXBIT.
  - Run counter == STUFF_LEN and RXBIT == last: stuff error. STUFF_ERR=1 at t+1, no BITSTB; go to ERROR, recessive counter starts from this sample.
- FRAME, SAMPLE with STUFF_EN=0:
  - Every bit passes (BITSTB at t+1); no stuff checks.
  - Run counter forced to 1 with last=RXBIT, so re-enabling starts a fresh run.
  - Recessive counter reaching IDLE_BITS -> IDLE. ACK delimiter + EOF + intermission = 11, so a back-to-back SOF is accepted on the next sample.
- STUFF_EN toggling outside SAMPLE cycles has no effect.
- BITCNT saturates at 2^CNT_W-1 and is never wrapped.
- BITSTB and CRC_CLEAR are never high in the same cycle.

Decomposition:
- Shared package can_pkg:
  - State enumeration (WAIT_IDLE, IDLE, FRAME, ERROR).
  - Constants CAN_STUFF_LEN=5, CAN_IDLE_BITS=11.
  - Recessive/dominant level constants, shared with frame FSM and encoder.
- One natural sub-module: can_run_counter. It implements the saturating equal-bit / recessive run counter with clear/increment, instantiated twice (stuff run, recessive run).

Test Plan:
- Idle detection: 10 recessive samples -> BUS_IDLE stays 0; 11th -> BUS_IDLE=1 one cycle later. A dominant sample at count 7 restarts the count.
- SOF: from IDLE, RXBIT=0 -> CRC_CLEAR=SOF=1 at t+1; BITSTB with BITOUT=0 at t+2; BITCNT=1.
- Destuff: with STUFF_EN=1, bits after SOF 0,0,0,0,[1 stuff],1,0 -> BITSTB for 0,0,0,0,1,0 only. BITCNT=7. Output fed to crc_checker matches reference CRC of 0000010.
- Stuff error: SOF then 0,0,0,0,0 (six dominant) -> STUFF_ERR=1, no 6th BITSTB, state ERROR. 11 recessive -> BUS_IDLE=1; next SOF clears STUFF_ERR.
- STUFF_EN=0 window: six 1s pass with six BITSTB, no error. 11 recessive -> IDLE; immediate dominant -> new SOF pulse.
- Reset mid-frame: RESET_N low after 20 bits -> all outputs 0 asynchronously. After release, no BITSTB until 11 recessive + SOF.
